ppc_fetch_queue: RTL

//  Instruction fetch stage upstream of the PPC decode/execute core. Owns the fetch PC and issues

---
 rtl/ppc_pkg.sv | 16 +
 rtl/ppc_ifq_fifo.sv | 58 +++++
 rtl/ppc_fetch_queue.sv | 112 +++++++++++
 3 files changed

// File: rtl/ppc_pkg.sv
// ppc_pkg: shared widths, fetch entry type and word-select helper for the fetch queue
package ppc_pkg;
    localparam int INST_W    = 32;
    localparam int ADDR_W    = 64;
    localparam int DW_ADDR_W = 61;

    typedef struct packed {
        logic [0:ADDR_W-1] pc;
        logic [0:INST_W-1] inst;
    } fetch_entry_t;

    // Big-endian doubleword: word 0 is the high half, word 1 the low half.
    function automatic logic [0:INST_W-1] word_sel(input logic [0:2*INST_W-1] dw, input logic hi);
        return hi ? dw[INST_W:2*INST_W-1] : dw[0:INST_W-1];
    endfunction
endpackage

// File: rtl/ppc_ifq_fifo.sv
// ppc_ifq_fifo: DEPTH-entry {pc,inst} FIFO with 0-2 writes and 1 read per cycle
//   clk, rst      clock, asynchronous active-high reset
//   i_clr         synchronous flush (wins over push/pop)
//   i_push_n      number of entries written this cycle (0..2), i_d0 first then i_d1
//   i_pop         consume head (ignored when empty)
//   o_head        head entry, zero when empty
//   o_valid       FIFO not empty
//   o_count       occupancy 0..DEPTH
module ppc_ifq_fifo
    import ppc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_clr,
    input  logic [1:0]             i_push_n,
    input  fetch_entry_t           i_d0,
    input  fetch_entry_t           i_d1,
    input  logic                   i_pop,
    output fetch_entry_t           o_head,
    output logic                   o_valid,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [CW-1:0] r_cnt;
    logic          w_pop;

    assign o_valid = r_cnt != '0;
    assign w_pop   = i_pop & o_valid;
    assign o_head  = o_valid ? r_mem[r_rd] : '0;
    assign o_count = r_cnt;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else if (i_clr) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            r_wr  <= r_wr + PW'(i_push_n);
            r_rd  <= r_rd + PW'(w_pop);
            r_cnt <= r_cnt + CW'(i_push_n) - CW'(w_pop);
        end

    always_ff @(posedge clk) begin
        if (i_push_n != 2'd0) r_mem[r_wr] <= i_d0;
        if (i_push_n == 2'd2) r_mem[r_wr + PW'(1)] <= i_d1;
    end
endmodule

// File: rtl/ppc_fetch_queue.sv
// ppc_fetch_queue: fetch PC owner issuing doubleword reads and buffering instructions for decode
//   clk, rst                         clock, asynchronous active-high reset
//   redirect_valid/redirect_pc       flush and restart fetch at redirect_pc (low 2 bits ignored)
//   mem_req_valid/ready/addr         doubleword read request (addr = fetch_pc[0:60])
//   mem_rsp_valid/data               in-order read data
//   inst_valid/ready, inst, inst_pc  FIFO head to decode
// Build option PPC_FETCH_PAIR_EN: an aligned read delivers both words of the doubleword.
module ppc_fetch_queue
    import ppc_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter int                MAX_OUT  = 2,
    parameter logic [0:ADDR_W-1] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   redirect_valid,
    input  logic [0:ADDR_W-1]      redirect_pc,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic [0:DW_ADDR_W-1]   mem_req_addr,
    input  logic                   mem_rsp_valid,
    input  logic [0:2*INST_W-1]    mem_rsp_data,
    output logic                   inst_valid,
    input  logic                   inst_ready,
    output logic [0:INST_W-1]      inst,
    output logic [0:ADDR_W-1]      inst_pc
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int OW = $clog2(MAX_OUT + 1);
`ifdef PPC_FETCH_PAIR_EN
    localparam bit PAIR = 1'b1;
`else
    localparam bit PAIR = 1'b0;
`endif

    logic [0:ADDR_W-1] r_fetch_pc;
    logic [0:ADDR_W-1] r_resp_pc;
    logic [OW-1:0]     r_out;
    logic [OW-1:0]     r_drop;
    logic [CW-1:0]     r_resv;
    logic [CW-1:0]     w_count;
    logic [CW-1:0]     w_free;
    logic [1:0]        w_req_words;
    logic [1:0]        w_rsp_words;
    logic [1:0]        w_push_n;
    logic              w_req_fire;
    logic              w_rsp;
    logic              w_keep;
    fetch_entry_t      w_d0;
    fetch_entry_t      w_d1;
    fetch_entry_t      w_head;

    assign w_req_words = (PAIR && !r_fetch_pc[61]) ? 2'd2 : 2'd1;
    assign w_rsp_words = (PAIR && !r_resp_pc[61]) ? 2'd2 : 2'd1;
    // Free space counts words already promised to in-flight reads, so responses never overflow.
    assign w_free      = CW'(DEPTH) - w_count - r_resv;
    assign mem_req_valid = ~rst & ~redirect_valid & (r_out < OW'(MAX_OUT)) & (w_free >= CW'(w_req_words));
    assign mem_req_addr  = r_fetch_pc[0:DW_ADDR_W-1];
    assign w_req_fire  = mem_req_valid & mem_req_ready;
    // Stray responses with nothing outstanding are ignored.
    assign w_rsp       = mem_rsp_valid & (r_out != '0);
    assign w_keep      = w_rsp & (r_drop == '0) & ~redirect_valid;
    assign w_push_n    = w_keep ? w_rsp_words : 2'd0;

    always_comb begin
        w_d0.pc   = r_resp_pc;
        w_d0.inst = word_sel(mem_rsp_data, r_resp_pc[61]);
        w_d1.pc   = r_resp_pc + ADDR_W'(4);
        w_d1.inst = word_sel(mem_rsp_data, 1'b1);
    end

    ppc_ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (redirect_valid),
        .i_push_n (w_push_n),
        .i_d0     (w_d0),
        .i_d1     (w_d1),
        .i_pop    (inst_ready),
        .o_head   (w_head),
        .o_valid  (inst_valid),
        .o_count  (w_count)
    );

    assign inst    = w_head.inst;
    assign inst_pc = w_head.pc;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_out      <= '0;
            r_drop     <= '0;
            r_resv     <= '0;
        end else if (redirect_valid) begin
            // Every read still in flight after this cycle belongs to the old path.
            r_fetch_pc <= redirect_pc & ~64'd3;
            r_resp_pc  <= redirect_pc & ~64'd3;
            r_out      <= r_out - OW'(w_rsp);
            r_drop     <= r_out - OW'(w_rsp);
            r_resv     <= '0;
        end else begin
            r_out  <= r_out + OW'(w_req_fire) - OW'(w_rsp);
            r_resv <= r_resv + CW'(w_req_fire ? w_req_words : 2'd0) - CW'(w_push_n);
            if (w_req_fire) r_fetch_pc <= r_fetch_pc + ADDR_W'({w_req_words, 2'b00});
            if (w_rsp && r_drop != '0) r_drop <= r_drop - OW'(1);
            if (w_keep) r_resp_pc <= r_resp_pc + ADDR_W'({w_rsp_words, 2'b00});
        end

    a_rsp_outstanding: assert property (@(posedge clk) disable iff (rst) !(mem_rsp_valid && r_out == '0));
endmodule
